// File: rtl/cache_fill_controller.sv
// Miss-handling sequencer for the I/D caches: arbitrates misses onto one memory port,
// streams 8 returned words into the winning cache, then writes its tag/valid metadata.
module cache_fill_controller #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_data_valid,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              icache_wr_data,
  output logic              icache_wr_meta,
  output logic              dcache_wr_data,
  output logic              dcache_wr_meta,
  output logic              icache_busy,
  output logic              dcache_busy
);

  localparam int CNT_W = $clog2(WORDS);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, META} state_t;

  state_t            state, state_next;
  logic              grant_dcache;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  recv_cnt;
  logic              issue_done;
  logic              word_wr;
  logic              last_word;

  assign word_wr   = (state == FILL) && mem_data_valid;
  assign last_word = word_wr && (recv_cnt == CNT_W'(WORDS - 1));

  // Busy is decoded straight from registered state so reset drops it asynchronously.
  assign icache_busy = (state != IDLE) && !grant_dcache;
  assign dcache_busy = (state != IDLE) &&  grant_dcache;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      grant_dcache <= 1'b0;
      base         <= '0;
      issue_cnt    <= '0;
      recv_cnt     <= '0;
      issue_done   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          issue_cnt  <= '0;
          recv_cnt   <= '0;
          issue_done <= 1'b0;
          if (dcache_miss) begin
            grant_dcache <= 1'b1;
            base         <= dcache_addr & BLK_MASK;
          end else if (icache_miss) begin
            grant_dcache <= 1'b0;
            base         <= icache_addr & BLK_MASK;
          end
        end
        FILL: begin
          // issue_cnt holds at the last index; issue_done marks all requests sent.
          if (!issue_done) begin
            if (issue_cnt == CNT_W'(WORDS - 1)) issue_done <= 1'b1;
            else                                issue_cnt  <= issue_cnt + 1'b1;
          end
          if (word_wr) recv_cnt <= recv_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next     = state;
    mem_enable     = 1'b0;
    mem_addr       = '0;
    fill_addr      = '0;
    fill_data      = '0;
    icache_wr_data = 1'b0;
    icache_wr_meta = 1'b0;
    dcache_wr_data = 1'b0;
    dcache_wr_meta = 1'b0;
    case (state)
      IDLE: begin
        if (dcache_miss || icache_miss) state_next = FILL;
      end
      FILL: begin
        if (!issue_done) begin
          mem_enable = 1'b1;
          mem_addr   = base | ADDR_W'({issue_cnt, 1'b0});
        end
        if (word_wr) begin
          fill_data      = mem_data_in;
          fill_addr      = base | ADDR_W'({recv_cnt, 1'b0});
          icache_wr_data = !grant_dcache;
          dcache_wr_data =  grant_dcache;
        end
        if (last_word) state_next = META;
      end
      META: begin
        fill_addr      = base;
        icache_wr_meta = !grant_dcache;
        dcache_wr_meta =  grant_dcache;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_controller.sv
// Directed bench for cache_fill_controller with a latency/gap-configurable memory model.
module tb_cache_fill_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_miss, dcache_miss;
  logic [15:0] icache_addr, dcache_addr;
  logic [15:0] mem_data_in = '0;
  logic        mem_data_valid = 1'b0;
  logic        mem_enable;
  logic [15:0] mem_addr, fill_addr, fill_data;
  logic        icache_wr_data, icache_wr_meta, dcache_wr_data, dcache_wr_meta;
  logic        icache_busy, dcache_busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  cache_fill_controller #(.ADDR_W(16), .DATA_W(16), .WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .icache_miss(icache_miss), .icache_addr(icache_addr),
    .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
    .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
    .mem_enable(mem_enable), .mem_addr(mem_addr),
    .fill_addr(fill_addr), .fill_data(fill_data),
    .icache_wr_data(icache_wr_data), .icache_wr_meta(icache_wr_meta),
    .dcache_wr_data(dcache_wr_data), .dcache_wr_meta(dcache_wr_meta),
    .icache_busy(icache_busy), .dcache_busy(dcache_busy)
  );

  always #5 clk = ~clk;

  // Memory model: each request returns addr^5A3C after lat cycles, spaced by at least gap idle cycles.
  typedef struct packed {
    logic [31:0] due;
    logic [15:0] addr;
  } req_t;

  req_t        q[$];
  int unsigned cyc = 0;
  int unsigned lat = 4;
  int unsigned gap = 0;
  int unsigned last_due = 0;
  logic        spur = 1'b0;

  always begin
    req_t r;
    int unsigned d;
    @(posedge clk);
    cyc++;
    #1;
    mem_data_valid = spur;
    if (rst && q.size() > 0 && q[0].due <= cyc) begin
      r = q.pop_front();
      mem_data_valid = 1'b1;
      mem_data_in = r.addr ^ 16'h5A3C;
    end
    @(negedge clk);
    if (!rst) begin
      q.delete();
    end else if (mem_enable) begin
      d = cyc + lat;
      if (last_due + gap + 1 > d) d = last_due + gap + 1;
      last_due = d;
      q.push_back('{due: d, addr: mem_addr});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_strobes"}, {28'd0, icache_wr_data, icache_wr_meta, dcache_wr_data, dcache_wr_meta}, 32'd0);
    check_eq({tag, "_busy"}, {30'd0, icache_busy, dcache_busy}, 32'd0);
    check_eq({tag, "_mem"}, {15'd0, mem_enable, mem_addr}, 32'd0);
  endtask

  // Observes one fill at negedges until the metadata write, then the following IDLE cycle.
  task automatic run_fill(input logic is_d, input logic [15:0] base, input int raise_i_at,
                          input logic ninth, output int busy_cycles, output int wait_cycles);
    int   issued, recv;
    logic done, seen_busy;
    logic own_wd, own_wm, own_busy, oth_wd, oth_wm, oth_busy;
    issued = 0; recv = 0; busy_cycles = 0; wait_cycles = 0; done = 0; seen_busy = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (n == raise_i_at) icache_miss = 1'b1;
      own_wd   = is_d ? dcache_wr_data : icache_wr_data;
      own_wm   = is_d ? dcache_wr_meta : icache_wr_meta;
      own_busy = is_d ? dcache_busy    : icache_busy;
      oth_wd   = is_d ? icache_wr_data : dcache_wr_data;
      oth_wm   = is_d ? icache_wr_meta : dcache_wr_meta;
      oth_busy = is_d ? icache_busy    : dcache_busy;
      check_eq("other_wr_data", oth_wd, 0);
      check_eq("other_wr_meta", oth_wm, 0);
      check_eq("other_busy", oth_busy, 0);
      if (own_busy) begin
        busy_cycles++;
        seen_busy = 1'b1;
      end else if (!seen_busy) begin
        wait_cycles++;
      end
      if (issued > 0 && issued < 8) check_eq("issue_contig", mem_enable, 1);
      if (mem_enable) begin
        check_eq("issue_count", 32'(issued < 8), 1);
        check_eq("mem_addr", mem_addr, 32'(base | 16'(issued * 2)));
        issued++;
      end
      if (own_wd) begin
        check_eq("recv_count", 32'(recv < 8), 1);
        check_eq("fill_addr", fill_addr, 32'(base | 16'(recv * 2)));
        check_eq("fill_data", fill_data, 32'((base | 16'(recv * 2)) ^ 16'h5A3C));
        recv++;
        if (ninth && recv == 8) spur = 1'b1;
      end
      if (own_wm) begin
        check_eq("meta_after_8", recv, 8);
        check_eq("meta_addr", fill_addr, base);
        check_eq("meta_no_data", own_wd, 0);
        done = 1'b1;
      end
    end
    check_eq("fill_done", done, 1);
    @(negedge clk);
    spur = 1'b0;
    check_eq("post_meta_strobes", {icache_wr_data, icache_wr_meta, dcache_wr_data, dcache_wr_meta}, 0);
    check_eq("post_meta_busy", {icache_busy, dcache_busy}, 0);
    if (is_d) dcache_miss = 1'b0;
    else      icache_miss = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bc, wc;
    rst = 1'b0; icache_miss = 1'b0; dcache_miss = 1'b0;
    icache_addr = '0; dcache_addr = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_fill", {fill_addr, fill_data}, 0);
    check_idle("rst");
    rst = 1'b1;

    // Reset in the middle of a fill
    lat = 4; gap = 0;
    @(posedge clk); #1;
    dcache_addr = 16'h2222; dcache_miss = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("midfill_busy", dcache_busy, 1);
    check_eq("midfill_en", mem_enable, 1);
    rst = 1'b0;
    #1;
    check_idle("async_rst");
    check_eq("async_rst_fill", {fill_addr, fill_data}, 0);
    dcache_miss = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("after_rst");
    end

    // Single D miss, latency 4
    @(posedge clk); #1;
    dcache_addr = 16'h1234; dcache_miss = 1'b1;
    run_fill(1'b1, 16'h1230, -1, 1'b0, bc, wc);
    check_eq("d_busy_cycles", bc, 13);
    check_eq("d_wait", wc, 1);

    // Simultaneous misses, D wins
    lat = 2;
    @(posedge clk); #1;
    icache_addr = 16'h0400; dcache_addr = 16'h8008;
    icache_miss = 1'b1; dcache_miss = 1'b1;
    run_fill(1'b1, 16'h8000, -1, 1'b0, bc, wc);
    check_eq("both_d_busy", bc, 11);
    check_eq("both_d_wait", wc, 1);
    run_fill(1'b0, 16'h0400, -1, 1'b0, bc, wc);
    check_eq("both_i_busy", bc, 11);
    check_eq("both_i_wait", wc, 0);

    // Latency 1, bursty returns
    lat = 1; gap = 2;
    @(posedge clk); #1;
    icache_addr = 16'h0ABC; icache_miss = 1'b1;
    run_fill(1'b0, 16'h0AB0, -1, 1'b0, bc, wc);
    check_eq("bursty_busy", bc, 24);
    check_eq("bursty_wait", wc, 1);
    gap = 0;

    // Spurious valid in IDLE, then a 9th valid during META
    @(posedge clk); #1;
    spur = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("spur_idle");
    end
    spur = 1'b0;
    lat = 2;
    @(posedge clk); #1;
    dcache_addr = 16'h4560; dcache_miss = 1'b1;
    run_fill(1'b1, 16'h4560, -1, 1'b1, bc, wc);
    check_eq("ninth_busy", bc, 11);
    repeat (2) begin
      @(negedge clk);
      check_idle("ninth_idle");
    end

    // I miss arriving mid D fill is granted right after D's META
    lat = 3;
    @(posedge clk); #1;
    dcache_addr = 16'h7777; icache_addr = 16'h0C0C; dcache_miss = 1'b1;
    run_fill(1'b1, 16'h7770, 4, 1'b0, bc, wc);
    check_eq("late_d_busy", bc, 12);
    check_eq("late_d_wait", wc, 1);
    run_fill(1'b0, 16'h0C00, -1, 1'b0, bc, wc);
    check_eq("late_i_busy", bc, 12);
    check_eq("late_i_wait", wc, 0);
    @(negedge clk);
    check_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
